// File: rtl/mac_learn_pkg.sv
// Shared definitions for the MAC learn scheduler.
//   OP_LEARN / OP_AGE : table command opcodes driven on tbl_op
//   MAC_W             : MAC address width
//   tbl_cmd_t         : registered table command {op, mac, port, index}
// The port and index fields are sized for the default configuration
// (NUM_PORTS = 7, TABLE_DEPTH = 256); smaller configurations use the low bits.
package mac_learn_pkg;

   localparam int unsigned MAC_W      = 48;
   localparam int unsigned CMD_PORT_W = 3;
   localparam int unsigned CMD_IDX_W  = 8;

   localparam logic [1:0] OP_LEARN = 2'd0;
   localparam logic [1:0] OP_AGE   = 2'd1;

   typedef struct packed {
      logic [1:0]            op;
      logic [MAC_W-1:0]      mac;
      logic [CMD_PORT_W-1:0] port;
      logic [CMD_IDX_W-1:0]  index;
   } tbl_cmd_t;

endpackage

// File: rtl/mac_learn_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector
//   ptr_i : highest-priority position; search runs upward from here with wrap
//   gnt_o : one-hot grant, zero when no request
//   idx_o : index of the granted bit (0 when no request)
module rr_arbiter #(
   parameter int unsigned N     = 7,
   parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [PTR_W-1:0] idx_o
);

   int   cand;
   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = 0;
      for (int i = 0; i < int'(N); i++) begin
         cand = int'(ptr_i) + i;
         if (cand >= int'(N)) begin
            cand = cand - int'(N);
         end
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = PTR_W'(cand);
         end
      end
   end

endmodule

// File: rtl/mac_learn_scheduler.sv
// Shares the MAC table write port among NUM_PORTS ingress learn requesters.
// Learn requests are arbitrated round-robin; one table command is issued per
// tbl_valid/tbl_ready handshake. With MAC_LEARN_AGING_EN defined, a periodic
// aging scan over every table index is issued in slots with no learn request.
// Ports:
//   axis_aclk, axis_reset : clock, asynchronous active-high reset
//   req_valid/req_ready   : per-port learn request / one-hot accept
//   req_mac_flat          : per-port source MAC, port i at [i*MAC_W +: MAC_W]
//   tbl_valid/tbl_ready   : table command handshake
//   tbl_op/mac/port/index : command payload (held stable while stalled)
//   age_overrun           : sticky, aging period expired with a scan still pending
// Build option: MAC_LEARN_AGING_EN enables the aging timer and scan.
module mac_learn_scheduler
   import mac_learn_pkg::*;
#(
   parameter int unsigned NUM_PORTS   = 7,
   parameter int unsigned TABLE_DEPTH = 256,
   parameter int unsigned AGE_PERIOD  = 1250
) (
   input  logic                             axis_aclk,
   input  logic                             axis_reset,
   input  logic [NUM_PORTS-1:0]             req_valid,
   output logic [NUM_PORTS-1:0]             req_ready,
   input  logic [NUM_PORTS*MAC_W-1:0]       req_mac_flat,
   output logic                             tbl_valid,
   input  logic                             tbl_ready,
   output logic [1:0]                       tbl_op,
   output logic [MAC_W-1:0]                 tbl_mac,
   output logic [$clog2(NUM_PORTS)-1:0]     tbl_port,
   output logic [$clog2(TABLE_DEPTH)-1:0]   tbl_index,
   output logic                             age_overrun
);

   localparam int unsigned PORT_W = $clog2(NUM_PORTS);
   localparam int unsigned IDX_W  = $clog2(TABLE_DEPTH);

   if (NUM_PORTS < 2 || PORT_W > CMD_PORT_W || IDX_W > CMD_IDX_W || AGE_PERIOD < 2)
   begin : g_bad_cfg
      $error("mac_learn_scheduler: unsupported parameter combination");
   end

   typedef enum logic {StIdle, StIssue} state_t;

   state_t              state_q, state_d;
   logic                valid_q, valid_d;
   tbl_cmd_t            cmd_q, cmd_d;
   logic [PORT_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_PORTS-1:0] gnt;
   logic [PORT_W-1:0]   win_idx;

`ifdef MAC_LEARN_AGING_EN
   localparam int unsigned TMR_W = $clog2(AGE_PERIOD);
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
   logic             pending_q, pending_d;
   logic             overrun_q, overrun_d;
   logic             timer_tc;
`endif

   rr_arbiter #(
      .N     (NUM_PORTS),
      .PTR_W (PORT_W)
   ) u_rr_arbiter (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (win_idx)
   );

   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      cmd_d    = cmd_q;
      rr_ptr_d = rr_ptr_q;
`ifdef MAC_LEARN_AGING_EN
      timer_tc   = (timer_q == TMR_W'(AGE_PERIOD - 1));
      timer_d    = timer_tc ? '0 : timer_q + 1'b1;
      scan_idx_d = scan_idx_q;
      pending_d  = pending_q;
      overrun_d  = overrun_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (|req_valid) begin
               cmd_d.op                = OP_LEARN;
               cmd_d.mac               = req_mac_flat[int'(win_idx)*MAC_W +: MAC_W];
               cmd_d.port              = '0;
               cmd_d.port[PORT_W-1:0]  = win_idx;
               cmd_d.index             = '0;
               rr_ptr_d = (win_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
               valid_d  = 1'b1;
               state_d  = StIssue;
            end
`ifdef MAC_LEARN_AGING_EN
            else if (pending_q) begin
               cmd_d.op               = OP_AGE;
               cmd_d.mac              = '0;
               cmd_d.port             = '0;
               cmd_d.index            = '0;
               cmd_d.index[IDX_W-1:0] = scan_idx_q;
               valid_d = 1'b1;
               state_d = StIssue;
            end
`endif
         end
         StIssue: begin
            if (tbl_ready) begin
               valid_d = 1'b0;
               state_d = StIdle;
`ifdef MAC_LEARN_AGING_EN
               if (cmd_q.op == OP_AGE) begin
                  if (scan_idx_q == IDX_W'(TABLE_DEPTH - 1)) begin
                     scan_idx_d = '0;
                     pending_d  = 1'b0;
                  end else begin
                     scan_idx_d = scan_idx_q + 1'b1;
                  end
               end
`endif
            end
         end
      endcase
`ifdef MAC_LEARN_AGING_EN
      // Terminal count wins over a scan completing in the same cycle, so a
      // fresh scan restarts at index 0.
      if (timer_tc) begin
         if (pending_q) begin
            overrun_d = 1'b1;
         end
         pending_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge axis_aclk or posedge axis_reset) begin
      if (axis_reset) begin
         state_q    <= StIdle;
         valid_q    <= 1'b0;
         cmd_q      <= '0;
         rr_ptr_q   <= '0;
`ifdef MAC_LEARN_AGING_EN
         timer_q    <= '0;
         scan_idx_q <= '0;
         pending_q  <= 1'b0;
         overrun_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         cmd_q      <= cmd_d;
         rr_ptr_q   <= rr_ptr_d;
`ifdef MAC_LEARN_AGING_EN
         timer_q    <= timer_d;
         scan_idx_q <= scan_idx_d;
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
`endif
      end
   end

   // Gated by reset so no accept is signalled while the FSM cannot capture it.
   assign req_ready = (state_q == StIdle && !axis_reset) ? gnt : '0;
   assign tbl_valid = valid_q;
   assign tbl_op    = cmd_q.op;
   assign tbl_mac   = cmd_q.mac;
   assign tbl_port  = cmd_q.port[PORT_W-1:0];
   assign tbl_index = cmd_q.index[IDX_W-1:0];
`ifdef MAC_LEARN_AGING_EN
   assign age_overrun = overrun_q;
`else
   assign age_overrun = 1'b0;
`endif

endmodule
